muldiv_unit: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined MIPS core. It accepts a mult/multu/div/divu from the Execute stage and runs a 32-step shift-add or restoring-divide state machine. While it runs it holds `busy` so the hazard unit can stall dependent `mfhi`/`mflo` and further mul/div ops. It also services `mthi`/`mtlo` writes and supplies HI/LO to the Memory-stage `mfhi`/`mflo` mux.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Execute-stage request and HI/LO result bundle for the mul/div sequencer.
// The hazard unit watches busy; the Memory-stage mux reads hi/lo.
interface muldiv_unit_if;
  logic        startE;
  logic [1:0]  opE;
  logic        flushE;
  logic [31:0] srcaE;
  logic [31:0] srcbE;
  logic        hiweE;
  logic        loweE;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output startE, opE, flushE, srcaE, srcbE,
    output hiweE, loweE,
    input  busy, hi, lo
  );

  modport slave (
    input  startE, opE, flushE, srcaE, srcbE,
    input  hiweE, loweE,
    output busy, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-step multiply / restoring divide owning the HI/LO pair.
// Magnitudes are processed unsigned; signs are reapplied in FIX.
module muldiv_unit (
  input  logic   clk,
  input  logic   reset,
  muldiv_unit_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [31:0] mag;
  logic        div_q;
  logic        neg_p, neg_q, neg_r;
  logic [31:0] hi_q, lo_q;

  logic        accept, is_div, sgn;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum, div_trial;
  logic [63:0] mul_next, div_next, prod;
  logic [31:0] quot, rem;

  assign accept = (state == IDLE) && bus.startE && !bus.flushE;
  assign is_div = bus.opE[1];
  assign sgn    = ~bus.opE[0];
  assign a_neg  = sgn & bus.srcaE[31];
  assign b_neg  = sgn & bus.srcbE[31];
  assign a_mag  = a_neg ? (32'd0 - bus.srcaE) : bus.srcaE;
  assign b_mag  = b_neg ? (32'd0 - bus.srcbE) : bus.srcbE;

  // acc holds {upper, multiplier} for mult and {rem, quot} for div
  assign mul_sum   = {1'b0, acc[63:32]} + {1'b0, mag};
  assign mul_next  = acc[0] ? {mul_sum, acc[31:1]}
                            : {1'b0, acc[63:1]};
  assign div_trial = acc[63:31] - {1'b0, mag};
  assign div_next  = div_trial[32]
                   ? {acc[62:0], 1'b0}
                   : {div_trial[31:0], acc[30:0], 1'b1};

  assign prod = neg_p ? (64'd0 - acc) : acc;
  assign quot = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
  assign rem  = neg_r ? (32'd0 - acc[63:32]) : acc[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      acc   <= '0;
      mag   <= '0;
      div_q <= 1'b0;
      neg_p <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            div_q <= is_div;
            cnt   <= '0;
            if (is_div && bus.srcbE == 32'd0) begin
              // divide by zero: raw dividend to HI, all ones to LO
              acc   <= {bus.srcaE, 32'hFFFF_FFFF};
              mag   <= '0;
              neg_p <= 1'b0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= FIX;
            end else begin
              acc   <= {32'd0, is_div ? a_mag : b_mag};
              mag   <= is_div ? b_mag : a_mag;
              neg_p <= !is_div & (a_neg ^ b_neg);
              neg_q <= is_div & (a_neg ^ b_neg);
              neg_r <= is_div & a_neg;
              state <= CALC;
            end
          end else if (!bus.flushE) begin
            if (bus.hiweE) hi_q <= bus.srcaE;
            if (bus.loweE) lo_q <= bus.srcaE;
          end
        end
        CALC: begin
          acc <= div_q ? div_next : mul_next;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
          if (div_q) begin
            hi_q <= rem;
            lo_q <= quot;
          end else begin
            hi_q <= prod[63:32];
            lo_q <= prod[31:0];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table plus corner sequences and a random
// back-to-back run against a 64-bit reference model.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic reset;
  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int ncyc;
  vec_t vecs[12];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    bus.opE    = op;
    bus.srcaE  = a;
    bus.srcbE  = b;
    bus.startE = 1'b1;
    @(posedge clk);
    #1 bus.startE = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (!bus.busy) break;
      cyc++;
      if (cyc > 40) begin
        total++;
        bad++;
        $display("FAIL timeout: busy stuck after %0d cycles", cyc);
        break;
      end
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  initial begin
    logic [63:0] exp;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,        33, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{2'b11, 32'd100,       32'd7,        33, 32'd2,         32'd14};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'd0,         32'h8000_0000};
    vecs[5]  = '{2'b11, 32'h0000_1234, 32'd0,        1,  32'h0000_1234, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'd0};
    vecs[7]  = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFF, 32'h8000_0001};
    vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'd1,        33, 32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 33, 32'd1,         32'hFFFF_FFFD};
    vecs[10] = '{2'b10, 32'hFFFF_FFF9, 32'd0,        1,  32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[11] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 33, 32'd1,         32'd0};

    bus.startE = 0; bus.opE = 0; bus.flushE = 0;
    bus.srcaE = 0; bus.srcbE = 0; bus.hiweE = 0; bus.loweE = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'd0, bus.busy}, 32'd0);

    foreach (vecs[i]) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(ncyc);
      check($sformatf("vec%0d busy", i), ncyc, vecs[i].cyc);
      check($sformatf("vec%0d hi", i), bus.hi, vecs[i].hi);
      check($sformatf("vec%0d lo", i), bus.lo, vecs[i].lo);
    end

    // flushed start must not launch, nor may a flushed mthi land
    bus.flushE = 1'b1;
    bus.hiweE  = 1'b1;
    issue(2'b01, 32'h5555_5555, 32'd3);
    bus.flushE = 1'b0;
    bus.hiweE  = 1'b0;
    @(negedge clk);
    check("flush busy", {31'd0, bus.busy}, 32'd0);
    check("flush hi", bus.hi, 32'h0001_0000 >> 16);

    // second start and an mthi during CALC are both ignored
    issue(2'b11, 32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    bus.hiweE = 1'b1;
    issue(2'b01, 32'hA5A5_A5A5, 32'd2);
    bus.hiweE = 1'b0;
    wait_done(ncyc);
    check("midcalc hi", bus.hi, 32'd1);
    check("midcalc lo", bus.lo, 32'd111);

    // idle mthi / mtlo with one-cycle latency
    bus.srcaE = 32'hA5A5_A5A5;
    bus.hiweE = 1'b1;
    @(posedge clk);
    #1 bus.hiweE = 1'b0;
    check("mthi hi", bus.hi, 32'hA5A5_A5A5);
    check("mthi lo", bus.lo, 32'd111);
    bus.srcaE = 32'h0F0F_0F0F;
    bus.hiweE = 1'b1;
    bus.loweE = 1'b1;
    @(posedge clk);
    #1 bus.hiweE = 1'b0;
    bus.loweE = 1'b0;
    check("mthilo hi", bus.hi, 32'h0F0F_0F0F);
    check("mthilo lo", bus.lo, 32'h0F0F_0F0F);

    // reset after 10 steps of a mult aborts and clears HI/LO
    issue(2'b00, 32'd12345, 32'd678);
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort hi", bus.hi, 32'd0);
    check("abort lo", bus.lo, 32'd0);

    // random ops issued back to back right after busy drops
    for (int n = 0; n < 300; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'hFFFF_FFFF;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      exp = model(rop, ra, rb);
      issue(rop, ra, rb);
      wait_done(ncyc);
      check($sformatf("rnd%0d busy", n), ncyc,
            (rop[1] && rb == 0) ? 1 : 33);
      check($sformatf("rnd%0d op%0d %h %h hi", n, rop, ra, rb),
            bus.hi, exp[63:32]);
      check($sformatf("rnd%0d op%0d %h %h lo", n, rop, ra, rb),
            bus.lo, exp[31:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
